// File: rtl/add_sub_serial_pkg.sv
// Shared types, encodings and sizing helpers for the digit-serial adder/subtractor.
package add_sub_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Number of digit steps needed to cover one operand.
  function automatic int unsigned num_digits(input int unsigned data_size,
                                             input int unsigned digit_size);
    return (digit_size == 0) ? 1 : data_size / digit_size;
  endfunction

  // Digit counter width; a single-digit operation still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/add_sub_serial_digit_adder.sv
// Combinational DIGIT-wide adder; invert_b turns it into the subtract slice.
module add_sub_serial_digit_adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             invert_b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] b_eff_c;
  logic [WIDTH:0]   total_c;

  assign b_eff_c = invert_b ? ~b : b;
  assign total_c = (WIDTH+1)'(a) + (WIDTH+1)'(b_eff_c) + (WIDTH+1)'(cin);
  assign {cout, sum} = total_c;

endmodule

// File: rtl/add_sub_serial.sv
// Digit-serial add/sub: DIGIT_SIZE bits per clock, result and flags held until taken.
// Defining ADD_SUB_SERIAL_CARRY_IN_EN adds a carry/borrow input for multi-word chaining.
module add_sub_serial
  import add_sub_serial_pkg::*;
#(
  parameter int unsigned DATA_SIZE  = 16,
  parameter int unsigned DIGIT_SIZE = 4
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
`ifdef ADD_SUB_SERIAL_CARRY_IN_EN
  input  logic                 carry_in,
`endif
  input  logic                 valid_in,
  output logic                 ready_out,
  input  logic [DATA_SIZE-1:0] a_in,
  input  logic [DATA_SIZE-1:0] b_in,
  input  logic                 control_in,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic [DATA_SIZE-1:0] result_out,
  output logic                 carry_out,
  output logic                 overflow_out,
  output logic                 zero_out
);

  localparam int unsigned NUM_DIGITS = num_digits(DATA_SIZE, DIGIT_SIZE);
  localparam int unsigned CNT_W      = cnt_width(NUM_DIGITS);
  localparam int unsigned CAT_W      = DATA_SIZE + DIGIT_SIZE;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

  if ((DIGIT_SIZE == 0) || (DIGIT_SIZE > DATA_SIZE) ||
      ((DATA_SIZE % DIGIT_SIZE) != 0)) begin : g_bad_params
    $error("add_sub_serial: DATA_SIZE must be a non-zero multiple of DIGIT_SIZE");
  end

  state_e                state_q;
  logic [DATA_SIZE-1:0]  a_sh_q;
  logic [DATA_SIZE-1:0]  b_sh_q;
  logic [DATA_SIZE-1:0]  res_sh_q;
  logic                  ctrl_q;
  logic                  carry_q;
  logic                  a_msb_q;
  logic                  b_msb_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  ready_q;
  logic                  valid_q;
  logic [DATA_SIZE-1:0]  result_q;
  logic                  carry_out_q;
  logic                  overflow_q;
  logic                  zero_q;

  logic                  cin0_c;
  logic [DIGIT_SIZE-1:0] sum_c;
  logic                  cout_c;
  logic [CAT_W-1:0]      res_cat_c;
  logic [DATA_SIZE-1:0]  res_full_c;
  logic                  r_msb_c;
  logic                  ovf_c;

`ifdef ADD_SUB_SERIAL_CARRY_IN_EN
  assign cin0_c = control_in ^ carry_in;
`else
  assign cin0_c = control_in;
`endif

  // Single adder slice, fed the low digit of the operand shift registers each CALC cycle.
  add_sub_serial_digit_adder #(
    .WIDTH(DIGIT_SIZE)
  ) u_digit_adder (
    .a        (a_sh_q[DIGIT_SIZE-1:0]),
    .b        (b_sh_q[DIGIT_SIZE-1:0]),
    .cin      (carry_q),
    .invert_b (ctrl_q == OP_SUB),
    .sum      (sum_c),
    .cout     (cout_c)
  );

  // New digit enters at the top; after NUM_DIGITS shifts digit 0 sits at the LSB.
  assign res_cat_c  = {sum_c, res_sh_q};
  assign res_full_c = res_cat_c[CAT_W-1:DIGIT_SIZE];
  assign r_msb_c    = res_full_c[DATA_SIZE-1];
  assign ovf_c      = (ctrl_q == OP_SUB) ? ((a_msb_q != b_msb_q) && (r_msb_c != a_msb_q))
                                         : ((a_msb_q == b_msb_q) && (r_msb_c != a_msb_q));

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_sh_q    <= '0;
      ctrl_q      <= OP_ADD;
      carry_q     <= 1'b0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      valid_q     <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (valid_in && ready_q) begin
            a_sh_q  <= a_in;
            b_sh_q  <= b_in;
            ctrl_q  <= control_in;
            carry_q <= cin0_c;
            a_msb_q <= a_in[DATA_SIZE-1];
            b_msb_q <= b_in[DATA_SIZE-1];
            cnt_q   <= '0;
            ready_q <= 1'b0;
            state_q <= CALC;
          end
        end
        CALC: begin
          a_sh_q   <= a_sh_q >> DIGIT_SIZE;
          b_sh_q   <= b_sh_q >> DIGIT_SIZE;
          res_sh_q <= res_full_c;
          carry_q  <= cout_c;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            // Publish result and flags only once every digit is done.
            valid_q     <= 1'b1;
            result_q    <= res_full_c;
            carry_out_q <= (ctrl_q == OP_SUB) ? ~cout_c : cout_c;
            overflow_q  <= ovf_c;
            zero_q      <= (res_full_c == '0);
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          if (ready_in) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready_out    = ready_q;
  assign valid_out    = valid_q;
  assign result_out   = result_q;
  assign carry_out    = carry_out_q;
  assign overflow_out = overflow_q;
  assign zero_out     = zero_q;

endmodule

// File: tb/tb_add_sub_serial.sv
// Scoreboard bench for add_sub_serial at DIGIT_SIZE 4, 1 and 16 (DATA_SIZE 16).
`timescale 1ns/1ps
module tb_add_sub_serial;

  localparam int NI = 3;

  typedef struct {
    logic [15:0] res;
    logic        cy;
    logic        ov;
    logic        z;
    longint      cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i    [NI];
  logic        ctrl_i     [NI];
  logic [15:0] a_i        [NI];
  logic [15:0] b_i        [NI];
  logic        ready_i    [NI];
  logic        rdy_o      [NI];
  logic        vld_o      [NI];
  logic [15:0] res_o      [NI];
  logic        cy_o       [NI];
  logic        ov_o       [NI];
  logic        z_o        [NI];
  logic        manual     [NI];
  logic        manual_val [NI];
  logic        rnd_rdy    [NI];
`ifdef ADD_SUB_SERIAL_CARRY_IN_EN
  logic        cin_i      [NI];
`endif

  exp_t   exp_q [NI][$];
  exp_t   held  [NI];
  logic   held_ok [NI];
  logic   vprev [NI];
  bit     rand_bp;
  longint cyc = 0;
  int     n_vec = 0;
  int     n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned DG = (g == 0) ? 4 : (g == 1) ? 1 : 16;
    assign ready_i[g] = manual[g] ? manual_val[g] : rnd_rdy[g];
    add_sub_serial #(
      .DATA_SIZE  (16),
      .DIGIT_SIZE (DG)
    ) u_dut (
      .clk_in       (clk),
      .reset_in     (rst),
`ifdef ADD_SUB_SERIAL_CARRY_IN_EN
      .carry_in     (cin_i[g]),
`endif
      .valid_in     (valid_i[g]),
      .ready_out    (rdy_o[g]),
      .a_in         (a_i[g]),
      .b_in         (b_i[g]),
      .control_in   (ctrl_i[g]),
      .valid_out    (vld_o[g]),
      .ready_in     (ready_i[g]),
      .result_out   (res_o[g]),
      .carry_out    (cy_o[g]),
      .overflow_out (ov_o[g]),
      .zero_out     (z_o[g])
    );
  end

  function automatic int num_d(input int k);
    return (k == 0) ? 4 : (k == 1) ? 16 : 1;
  endfunction

  // Reference: plain wide arithmetic on unsigned and signed views of the operands.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic c, input logic ci, input longint when);
    exp_t        r;
    logic [16:0] full;
    int          s;
    if (c == 1'b0) begin
      full = {1'b0, a} + {1'b0, b} + 17'(ci);
      s    = int'($signed(a)) + int'($signed(b)) + int'(ci);
    end else begin
      full = {1'b0, a} - {1'b0, b} - 17'(ci);
      s    = int'($signed(a)) - int'($signed(b)) - int'(ci);
    end
    r.res = full[15:0];
    r.cy  = full[16];
    r.ov  = (s > 32767) || (s < -32768);
    r.z   = (full[15:0] == 16'h0000);
    r.cyc = when;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  // All driver activity is aligned to the falling edge.
  task automatic issue(input int k, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic ci);
    int g = 0;
    a_i[k] = a; b_i[k] = b; ctrl_i[k] = c; valid_i[k] = 1'b1;
`ifdef ADD_SUB_SERIAL_CARRY_IN_EN
    cin_i[k] = ci;
`endif
    while (!rdy_o[k] && g < 200) begin @(negedge clk); g++; end
    if (!rdy_o[k]) chk($sformatf("accept_timeout[%0d]", k), 32'(rdy_o[k]), 32'd1);
    else exp_q[k].push_back(model(a, b, c, ci, cyc + 1 + longint'(num_d(k))));
    @(negedge clk);
    valid_i[k] = 1'b0;
  endtask

  task automatic wait_check(input int k, input logic [15:0] r, input logic cy,
                            input logic ov, input logic z);
    int g = 0;
    while (!vld_o[k] && g < 100) begin @(negedge clk); g++; end
    chk($sformatf("valid_seen[%0d]", k), 32'(vld_o[k]), 32'd1);
    chk($sformatf("dir_result[%0d]", k), 32'(res_o[k]), 32'(r));
    chk($sformatf("dir_carry[%0d]", k), 32'(cy_o[k]), 32'(cy));
    chk($sformatf("dir_ovf[%0d]", k), 32'(ov_o[k]), 32'(ov));
    chk($sformatf("dir_zero[%0d]", k), 32'(z_o[k]), 32'(z));
  endtask

  task automatic drain();
    int  g = 0;
    bit  busy = 1'b1;
    while (busy && g < 3000) begin
      busy = 1'b0;
      for (int k = 0; k < NI; k++) if (exp_q[k].size() != 0 || vld_o[k]) busy = 1'b1;
      if (busy) begin @(negedge clk); g++; end
    end
    chk("drain_timeout", 32'(busy), 32'd0);
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Pops an expectation on each rising valid_out; checks hold-stability while valid stays up.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        rnd_rdy[k] = !rand_bp || ($urandom_range(0, 3) != 0);
        if (rst) begin
          vprev[k]   = 1'b0;
          held_ok[k] = 1'b0;
        end else begin
          if (vld_o[k] && !vprev[k]) begin
            if (exp_q[k].size() == 0) begin
              chk($sformatf("unexpected_result[%0d]", k), 32'(vld_o[k]), 32'd0);
            end else begin
              e = exp_q[k].pop_front();
              held[k] = e; held_ok[k] = 1'b1;
              chk($sformatf("result[%0d]", k), 32'(res_o[k]), 32'(e.res));
              chk($sformatf("carry[%0d]", k), 32'(cy_o[k]), 32'(e.cy));
              chk($sformatf("overflow[%0d]", k), 32'(ov_o[k]), 32'(e.ov));
              chk($sformatf("zero[%0d]", k), 32'(z_o[k]), 32'(e.z));
              chk($sformatf("latency[%0d]", k), 32'(cyc), 32'(e.cyc));
            end
          end else if (vld_o[k] && held_ok[k]) begin
            chk($sformatf("hold_stable[%0d]", k),
                {12'h0, cy_o[k], ov_o[k], z_o[k], 1'b0, res_o[k]},
                {12'h0, held[k].cy, held[k].ov, held[k].z, 1'b0, held[k].res});
          end
          vprev[k] = vld_o[k];
        end
      end
    end
  endtask

  task automatic driver();
    logic ci;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rst_valid[%0d]", k), 32'(vld_o[k]), 32'd0);
      chk($sformatf("rst_ready[%0d]", k), 32'(rdy_o[k]), 32'd0);
      chk($sformatf("rst_result[%0d]", k),
          {13'h0, cy_o[k], ov_o[k], z_o[k], res_o[k]}, 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NI; k++) chk($sformatf("post_rst_ready[%0d]", k), 32'(rdy_o[k]), 32'd1);

    // Directed cases with downstream always ready.
    issue(0, 16'h1234, 16'h0FFF, 1'b0, 1'b0); wait_check(0, 16'h2233, 1'b0, 1'b0, 1'b0);
    issue(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0); wait_check(0, 16'h0000, 1'b1, 1'b0, 1'b1);
    issue(0, 16'h0003, 16'h0005, 1'b1, 1'b0); wait_check(0, 16'hFFFE, 1'b1, 1'b0, 1'b0);
    issue(0, 16'h8000, 16'h0001, 1'b1, 1'b0); wait_check(0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    issue(1, 16'h1234, 16'h0FFF, 1'b0, 1'b0); wait_check(1, 16'h2233, 1'b0, 1'b0, 1'b0);
    issue(2, 16'h1234, 16'h0FFF, 1'b0, 1'b0); wait_check(2, 16'h2233, 1'b0, 1'b0, 1'b0);
    drain();

    // Back-pressure: result held, new operands ignored while HOLD.
    manual[0] = 1'b1; manual_val[0] = 1'b0;
    issue(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait_check(0, 16'h8000, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      valid_i[0] = ~valid_i[0]; a_i[0] = 16'($urandom); b_i[0] = 16'($urandom);
      @(negedge clk);
      chk("bp_ready_low", 32'(rdy_o[0]), 32'd0);
      chk("bp_valid_high", 32'(vld_o[0]), 32'd1);
      chk("bp_result", 32'(res_o[0]), 32'h8000);
    end
    valid_i[0] = 1'b0; manual_val[0] = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(vld_o[0]), 32'd0);
    chk("bp_release_ready", 32'(rdy_o[0]), 32'd1);
    manual[0] = 1'b0;
    repeat (8) @(negedge clk);

    // Reset in the second CALC cycle aborts the operation.
    issue(0, 16'h1234, 16'h0FFF, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 32'(vld_o[0]), 32'd0);
    chk("midrst_ready", 32'(rdy_o[0]), 32'd0);
    chk("midrst_result", {13'h0, cy_o[0], ov_o[0], z_o[0], res_o[0]}, 32'd0);
    exp_q[0].delete();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready_back", 32'(rdy_o[0]), 32'd1);
    repeat (20) @(negedge clk);

    // Randomized traffic with random downstream stalls.
    rand_bp = 1'b1;
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 40; i++) begin
`ifdef ADD_SUB_SERIAL_CARRY_IN_EN
        ci = 1'($urandom_range(0, 1));
`else
        ci = 1'b0;
`endif
        issue(k, pick(), pick(), 1'($urandom_range(0, 1)), ci);
      end
    end
    drain();
    for (int k = 0; k < NI; k++) chk($sformatf("leftover[%0d]", k), 32'(exp_q[k].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  endtask

  initial begin
    rst = 1'b1;
    rand_bp = 1'b0;
    for (int k = 0; k < NI; k++) begin
      valid_i[k] = 1'b0; ctrl_i[k] = 1'b0; a_i[k] = '0; b_i[k] = '0;
      manual[k] = 1'b0; manual_val[k] = 1'b0; rnd_rdy[k] = 1'b1;
      vprev[k] = 1'b0; held_ok[k] = 1'b0;
`ifdef ADD_SUB_SERIAL_CARRY_IN_EN
      cin_i[k] = 1'b0;
`endif
    end
    fork
      monitor();
      driver();
    join
  end

endmodule
